tag_pool_alloc: RTL and testbench
=================================

# tag_pool_alloc

Stateful tag/entry pool allocator. Owns the free bitmap of a `WIDTH`-entry resource (rename tags, LSQ slots, etc.) and grants up to four one-hot entries per cycle. Grants come from first-bit/second-first-bit and last-bit/second-last-bit pickers. Frees returned entries and recovers the whole pool on pipeline flush. Sits between the rename/dispatch stage (requesters) and the retire/flush logic (returners).

## Interface
Parameters:
- `WIDTH`, 32, number of pool entries (≥ 8).
- `INIT_FREE`, `{WIDTH{1'b1}}`, bitmap loaded at reset and on flush; zero bits are permanently reserved entries.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clkEn`  in  1  stage enable; low = no allocation, no state change from allocation.
- `needed`  in  4  per-slot allocation request; slot 0/1 take lowest entries, slot 2/3 take highest entries.
- `free_mask`  in  `WIDTH`  entries returned this cycle (any number of bits).
- `flush`  in  1  restore pool to `INIT_FREE`.
- `bitsOut0..3`  out  `WIDTH` each  one-hot grant per slot; zero when not granted.
- `doStall`  out  1  request cannot be served this cycle; no grants issued.
- `ready`  out  1  pool is in RUN state.
- `free_cnt`  out  `$clog2(WIDTH)+1`  registered count of free entries.
- `err`  out  1  sticky protocol error (see Configuration).

## Operation
- FSM states: INIT, RUN, FLUSH.
  - `rst` → INIT.
  - INIT → RUN after one cycle. Bitmap ← `INIT_FREE`; `free_cnt` ← popcount(`INIT_FREE`).
  - RUN → FLUSH when `flush`=1.
  - FLUSH → RUN next cycle. Bitmap and count reloaded as in INIT.
  - `flush` held high keeps the FSM in FLUSH.
- Grants (RUN only; combinational from the registered bitmap):
  - Slot 0 = lowest free entry; slot 1 = second lowest.
  - Slot 2 = highest free entry; slot 3 = second highest.
  - `bitsOutN` = pick & {`clkEn` & `needed[N]` & ~`doStall`}.
- `doStall` = `clkEn` & |`needed` & (`free_cnt` < 4 | state≠RUN).
  - The rule is conservative: it guarantees the four picks are distinct.
  - When stalled, no grant is issued and the bitmap is not changed by allocation.
- Bitmap update in RUN: next = (bitmap & ~granted) | `free_mask`.
- Count update in RUN: `free_cnt` next = `free_cnt` − popcount(granted) + popcount(`free_mask` & ~bitmap).
- Freed entries are never bypassed; they become allocatable the cycle after `free_mask`.
- `flush` has priority over grants and frees in the same cycle.
  - Grants are suppressed that cycle, `doStall`=1 if requested.
  - `free_mask` is ignored.
- `free_mask` bits that are already free, or outside `INIT_FREE`, are masked off (no count change).
- Reset outputs: `bitsOut*`=0, `doStall`=0 (or 1 if `clkEn`&|`needed`), `ready`=0, `free_cnt`=0, `err`=0.

## Timing
- Grant latency: 0 cycles (same cycle as request). Bitmap reflects the allocation at the next edge.
- Free-to-reuse latency: 1 cycle.
- Reset to first grant: 2 edges. Edge 1 enters INIT; edge 2 enters RUN.
- Flush to first grant: `flush` at edge N; grants available in the cycle after edge N+1.
- Reset asserted mid-allocation: pending grants are discarded and the bitmap is reloaded; no partial update.
- `free_cnt` is always equal to popcount(bitmap); the verifier checks this every cycle.

## Configuration
- `TAG_POOL_CHECK_EN` defined:
  - Sticky `err` sets on double free: `free_mask` bit already free and inside `INIT_FREE`.
  - `err` also sets on a grant overlapping `free_mask` in the same cycle.
  - `err` clears only on `rst`.
- Undefined: `err` tied 0 and no check logic is built.

## Structure
- Shared package holds:
  - the FSM state typedef (INIT/RUN/FLUSH, 2-bit encoding);
  - the grant-slot count constant (4);
  - the count width function.
- One natural sub-module: `tag_pool_pick`, the combinational four-way first/second-first/last/second-last picker on the bitmap. It is instantiated once.
- Popcounts are inline functions.

## Test plan
- Reset, `WIDTH`=32, `INIT_FREE`=all ones:
  - `ready`=0 for 1 cycle, then 1; `free_cnt`=32.
  - `needed`=4'b1111 → grants bit0, bit1, bit31, bit30; next `free_cnt`=28.
- Drain pool to `free_cnt`=3, then `needed`=4'b0001 → `doStall`=1, all `bitsOut`=0, `free_cnt` stays 3.
- Free bit5 via `free_mask` with `needed`=0001 the same cycle:
  - Bit5 is not granted that cycle.
  - Next cycle, with bits 0–4 allocated, slot 0 gets bit5.
- `flush` with `needed`=1111 and `free_mask`≠0:
  - No grants, `doStall`=1.
  - Next cycle state FLUSH; following cycle `free_cnt`=popcount(`INIT_FREE`).
- `INIT_FREE`=32'hFFFF_FFF0:
  - First grant slot 0 = bit4.
  - `free_mask`=bit2 → ignored, count unchanged.
- With `TAG_POOL_CHECK_EN`: free an already-free bit7 → `err`=1 next cycle, and it stays 1 until `rst`.

Source files
------------

// File: rtl/tag_pool_alloc_pkg.sv
// rtl/tag_pool_alloc_pkg.sv - shared types and constants for the tag pool allocator
// Holds the allocator FSM state encoding, the number of grant slots and the
// helper that sizes the free-entry counter.
package tag_pool_alloc_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  localparam int NUM_SLOTS = 4;

  // Counter must hold the value WIDTH itself, hence the extra bit.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/tag_pool_alloc_pick.sv
// rtl/tag_pool_alloc_pick.sv - four-way first/second/last/second-last bit picker
// Purpose: combinational picker over the free bitmap.
// Ports:
//   bitmap     in  WIDTH  free bitmap (1 = free)
//   lo_first   out WIDTH  one-hot lowest set bit (0 if none)
//   lo_second  out WIDTH  one-hot second-lowest set bit (0 if none)
//   hi_first   out WIDTH  one-hot highest set bit (0 if none)
//   hi_second  out WIDTH  one-hot second-highest set bit (0 if none)
module tag_pool_pick #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] bitmap,
  output logic [WIDTH-1:0] lo_first,
  output logic [WIDTH-1:0] lo_second,
  output logic [WIDTH-1:0] hi_first,
  output logic [WIDTH-1:0] hi_second
);

  logic [WIDTH-1:0] lo_rest;
  logic [WIDTH-1:0] rev;
  logic [WIDTH-1:0] rev_first;
  logic [WIDTH-1:0] rev_rest;
  logic [WIDTH-1:0] rev_second;

  // x & -x isolates the lowest set bit; clearing it and repeating gives the second.
  assign lo_first  = bitmap & (~bitmap + WIDTH'(1));
  assign lo_rest   = bitmap & ~lo_first;
  assign lo_second = lo_rest & (~lo_rest + WIDTH'(1));

  // High-side picks reuse the same trick on the bit-reversed bitmap.
  assign rev_first  = rev & (~rev + WIDTH'(1));
  assign rev_rest   = rev & ~rev_first;
  assign rev_second = rev_rest & (~rev_rest + WIDTH'(1));

  always_comb begin
    rev       = '0;
    hi_first  = '0;
    hi_second = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rev[i]                 = bitmap[WIDTH-1-i];
      hi_first[WIDTH-1-i]    = rev_first[i];
      hi_second[WIDTH-1-i]   = rev_second[i];
    end
  end

endmodule

// File: rtl/tag_pool_alloc.sv
// rtl/tag_pool_alloc.sv - stateful tag/entry pool allocator, up to four grants per cycle
// Purpose: owns the free bitmap of a WIDTH-entry pool; slots 0/1 grant the
// lowest free entries, slots 2/3 the highest. Returns and flush recovery.
// Optional macro: TAG_POOL_CHECK_EN builds the sticky protocol-error checker;
// without it err is tied low.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   clkEn      in   stage enable for allocation
//   needed     in   4-bit per-slot request
//   free_mask  in   WIDTH entries returned this cycle
//   flush      in   restore pool to INIT_FREE
//   bitsOut0-3 out  one-hot grant per slot
//   doStall    out  request cannot be served, no grants
//   ready      out  FSM in RUN
//   free_cnt   out  registered free-entry count
//   err        out  sticky protocol error
module tag_pool_alloc
  import tag_pool_alloc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] INIT_FREE = {WIDTH{1'b1}}
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clkEn,
  input  logic [NUM_SLOTS-1:0]        needed,
  input  logic [WIDTH-1:0]            free_mask,
  input  logic                        flush,
  output logic [WIDTH-1:0]            bitsOut0,
  output logic [WIDTH-1:0]            bitsOut1,
  output logic [WIDTH-1:0]            bitsOut2,
  output logic [WIDTH-1:0]            bitsOut3,
  output logic                        doStall,
  output logic                        ready,
  output logic [cnt_width(WIDTH)-1:0] free_cnt,
  output logic                        err
);

  localparam int CW = cnt_width(WIDTH);

  function automatic logic [CW-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] bitmap;
  logic [WIDTH-1:0] bitmap_next;
  logic [CW-1:0]    cnt_next;
  logic [WIDTH-1:0] pick_lo0;
  logic [WIDTH-1:0] pick_lo1;
  logic [WIDTH-1:0] pick_hi0;
  logic [WIDTH-1:0] pick_hi1;
  logic [WIDTH-1:0] granted;
  logic [WIDTH-1:0] freed;
  logic             run;
  logic             grant_en;

  tag_pool_pick #(.WIDTH(WIDTH)) u_pick (
    .bitmap    (bitmap),
    .lo_first  (pick_lo0),
    .lo_second (pick_lo1),
    .hi_first  (pick_hi0),
    .hi_second (pick_hi1)
  );

  assign run   = (state == ST_RUN);
  assign ready = run;

  // Requiring four free entries guarantees the low and high picks never
  // collide, whatever subset of slots is requesting.
  assign doStall  = clkEn & (|needed) & ((free_cnt < CW'(NUM_SLOTS)) | ~run | flush);
  assign grant_en = clkEn & ~doStall;

  assign bitsOut0 = (grant_en & needed[0]) ? pick_lo0 : '0;
  assign bitsOut1 = (grant_en & needed[1]) ? pick_lo1 : '0;
  assign bitsOut2 = (grant_en & needed[2]) ? pick_hi0 : '0;
  assign bitsOut3 = (grant_en & needed[3]) ? pick_hi1 : '0;
  assign granted  = bitsOut0 | bitsOut1 | bitsOut2 | bitsOut3;

  // Returns of entries already free or permanently reserved are dropped.
  assign freed = free_mask & ~bitmap & INIT_FREE;

  always_comb begin
    state_next  = state;
    bitmap_next = bitmap;
    cnt_next    = free_cnt;
    case (state)
      ST_INIT: begin
        state_next  = ST_RUN;
        bitmap_next = INIT_FREE;
        cnt_next    = popcnt(INIT_FREE);
      end
      ST_RUN: begin
        if (flush) begin
          state_next = ST_FLUSH;
        end else begin
          // granted bits are free and freed bits are not, so the terms are disjoint.
          bitmap_next = (bitmap & ~granted) | freed;
          cnt_next    = free_cnt - popcnt(granted) + popcnt(freed);
        end
      end
      ST_FLUSH: begin
        if (!flush) state_next = ST_RUN;
        bitmap_next = INIT_FREE;
        cnt_next    = popcnt(INIT_FREE);
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      bitmap   <= '0;
      free_cnt <= '0;
    end else begin
      state    <= state_next;
      bitmap   <= bitmap_next;
      free_cnt <= cnt_next;
    end
  end

`ifdef TAG_POOL_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (run && !flush &&
                 ((|(free_mask & bitmap & INIT_FREE)) || (|(granted & free_mask)))) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tag_pool_alloc.sv
// tb/tb_tag_pool_alloc.sv - self-checking bench for tag_pool_alloc
module tb_tag_pool_alloc;

  localparam logic [31:0] INIT0 = 32'hFFFF_FFFF;
  localparam logic [31:0] INIT1 = 32'hFFFF_FFF0;
`ifdef TAG_POOL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clkEn = 1'b0;
  logic [3:0]  needed = '0;
  logic [31:0] free_mask = '0;
  logic        flush = 1'b0;

  logic [31:0] bo [2][4];
  logic        ds [2];
  logic        rd [2];
  logic [5:0]  fc [2];
  logic        er [2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  tag_pool_alloc #(.WIDTH(32), .INIT_FREE(INIT0)) dut0 (
    .clk(clk), .rst(rst), .clkEn(clkEn), .needed(needed), .free_mask(free_mask), .flush(flush),
    .bitsOut0(bo[0][0]), .bitsOut1(bo[0][1]), .bitsOut2(bo[0][2]), .bitsOut3(bo[0][3]),
    .doStall(ds[0]), .ready(rd[0]), .free_cnt(fc[0]), .err(er[0]));

  tag_pool_alloc #(.WIDTH(32), .INIT_FREE(INIT1)) dut1 (
    .clk(clk), .rst(rst), .clkEn(clkEn), .needed(needed), .free_mask(free_mask), .flush(flush),
    .bitsOut0(bo[1][0]), .bitsOut1(bo[1][1]), .bitsOut2(bo[1][2]), .bitsOut3(bo[1][3]),
    .doStall(ds[1]), .ready(rd[1]), .free_cnt(fc[1]), .err(er[1]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: pool held as a plain bit set, picks found by scanning.
  logic [31:0] m_bm [2];
  logic        m_err [2];
  int          m_phase;   // 0 = init, 1 = run, 2 = flush
  bit          m_valid = 0;

  always @(negedge clk) begin
    logic [31:0] init_v, gr, e, nbm [2];
    logic        nerr [2];
    int          cnt, idx [4];
    bit          st, runm;
    for (int k = 0; k < 2; k++) begin
      init_v  = (k == 0) ? INIT0 : INIT1;
      nbm[k]  = m_bm[k];
      nerr[k] = m_err[k];
      gr      = '0;
      if (m_valid) begin
        cnt  = $countones(m_bm[k]);
        runm = (m_phase == 1);
        st   = clkEn && (needed != 0) && (cnt < 4 || !runm || flush);
        for (int n = 0; n < 4; n++) idx[n] = -1;
        for (int i = 0; i < 32; i++)
          if (m_bm[k][i]) begin
            if (idx[0] < 0) idx[0] = i; else if (idx[1] < 0) idx[1] = i;
          end
        for (int i = 31; i >= 0; i--)
          if (m_bm[k][i]) begin
            if (idx[2] < 0) idx[2] = i; else if (idx[3] < 0) idx[3] = i;
          end
        for (int n = 0; n < 4; n++) begin
          e = (clkEn && needed[n] && !st && idx[n] >= 0) ? (32'd1 << idx[n]) : 32'd0;
          gr |= e;
          chk($sformatf("bits%0d[%0d]", n, k), {32'd0, bo[k][n]}, {32'd0, e});
        end
        chk($sformatf("stall[%0d]", k), {63'd0, ds[k]}, {63'd0, st});
        chk($sformatf("ready[%0d]", k), {63'd0, rd[k]}, {63'd0, runm});
        chk($sformatf("cnt[%0d]", k), {58'd0, fc[k]}, 64'(cnt));
        chk($sformatf("err[%0d]", k), {63'd0, er[k]}, {63'd0, m_err[k]});
      end
      if (rst) begin
        nbm[k] = '0; nerr[k] = 1'b0;
      end else if (m_phase == 0 || m_phase == 2) begin
        nbm[k] = init_v;
      end else if (!flush) begin
        nbm[k] = (m_bm[k] & ~gr) | (free_mask & ~m_bm[k] & init_v);
        if (EXP_ERR && (((free_mask & m_bm[k] & init_v) != 0) || ((gr & free_mask) != 0)))
          nerr[k] = 1'b1;
      end
    end
    for (int k = 0; k < 2; k++) begin
      m_bm[k]  = nbm[k];
      m_err[k] = nerr[k];
    end
    if (rst) m_phase = 0;
    else if (m_phase == 0) m_phase = 1;
    else m_phase = flush ? 2 : 1;
    if (rst) m_valid = 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();                                   // reset edge: INIT
    #1;
    chk("rst_ready", {63'd0, rd[0]}, 64'd0);
    chk("rst_cnt", {58'd0, fc[0]}, 64'd0);
    chk("rst_bits0", {32'd0, bo[0][0]}, 64'd0);
    rst = 1'b0;
    step();                                   // INIT -> RUN
    #1;
    chk("run_ready", {63'd0, rd[0]}, 64'd1);
    chk("run_cnt0", {58'd0, fc[0]}, 64'd32);
    chk("run_cnt1", {58'd0, fc[1]}, 64'd28);
    clkEn = 1'b1; needed = 4'hF;
    #1;
    chk("g0", {32'd0, bo[0][0]}, 64'h1);
    chk("g1", {32'd0, bo[0][1]}, 64'h2);
    chk("g2", {32'd0, bo[0][2]}, 64'h8000_0000);
    chk("g3", {32'd0, bo[0][3]}, 64'h4000_0000);
    chk("g0_reserved", {32'd0, bo[1][0]}, 64'h10);
    step();
    #1;
    chk("cnt_after_grant", {58'd0, fc[0]}, 64'd28);
    repeat (6) step();
    needed = 4'b0001;
    step();
    #1;
    chk("drained_cnt", {58'd0, fc[0]}, 64'd3);
    chk("low_stall", {63'd0, ds[0]}, 64'd1);
    chk("low_nogrant", {32'd0, bo[0][0]}, 64'd0);
    step();
    #1;
    chk("low_cnt_hold", {58'd0, fc[0]}, 64'd3);
    free_mask = (32'd1 << 5) | (32'd1 << 20);
    #1;
    chk("free_no_bypass", {32'd0, bo[0][0]}, 64'd0);
    step();
    free_mask = '0;
    #1;
    chk("reuse_bit5", {32'd0, bo[0][0]}, 64'h20);
    step();
    #1;
    chk("cnt_after_reuse", {58'd0, fc[0]}, 64'd4);
    needed = '0; free_mask = 32'd1 << 2;
    step();
    free_mask = '0;
    #1;
    chk("free_bit2_cnt0", {58'd0, fc[0]}, 64'd5);
    chk("free_reserved_cnt1", {58'd0, fc[1]}, 64'd2);
    needed = 4'hF; free_mask = 32'd1 << 9; flush = 1'b1;
    #1;
    chk("flush_stall", {63'd0, ds[0]}, 64'd1);
    chk("flush_nogrant", {32'd0, bo[0][3]}, 64'd0);
    step();
    flush = 1'b0; needed = '0; free_mask = '0;
    #1;
    chk("flush_state_ready", {63'd0, rd[0]}, 64'd0);
    chk("flush_state_cnt", {58'd0, fc[0]}, 64'd5);
    step();
    #1;
    chk("flush_reload0", {58'd0, fc[0]}, 64'd32);
    chk("flush_reload1", {58'd0, fc[1]}, 64'd28);
    free_mask = 32'd1 << 7;
    step();
    free_mask = '0;
    #1;
    chk("dbl_free_err", {63'd0, er[0]}, {63'd0, EXP_ERR});
    repeat (3) step();
    #1;
    chk("dbl_free_sticky", {63'd0, er[0]}, {63'd0, EXP_ERR});

    repeat (3000) begin
      step();
      clkEn     = ($urandom_range(0, 9) != 0);
      needed    = 4'($urandom);
      free_mask = ($urandom_range(0, 2) == 0) ? ($urandom & $urandom & $urandom) : 32'd0;
      flush     = ($urandom_range(0, 59) == 0);
      rst       = ($urandom_range(0, 499) == 0);
    end
    step();
    rst = 1'b0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
